// File: rtl/seven_seg_scanner.sv
// seven_seg_scanner: time-multiplexed 5-digit seven-segment driver with
// frame-aligned double buffering and a per-slot blanking gap.
// Ports: clk, reset (sync, active-high), load, digits_in[19:0], dp_in[4:0]
//        -> seg_sel[4:0] (one-hot), seg_data[7:0] ({dp,g..a}), frame_start.
// Optional: define LEADING_ZERO_BLANK_EN to suppress leading-zero digits.
module seven_seg_scanner #(
    parameter int DIGIT_CYCLES = 50000,
    parameter int BLANK_CYCLES = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [19:0] digits_in,
    input  logic [4:0]  dp_in,
    output logic [4:0]  seg_sel,
    output logic [7:0]  seg_data,
    output logic        frame_start
);

    localparam int CW = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST  = CW'(DIGIT_CYCLES - 1);
    localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK_CYCLES);

    typedef enum logic {BLANK, SHOW} state_t;

    state_t      state, state_next;
    logic [CW-1:0] cnt, cnt_next;
    logic [2:0]  idx, idx_next;
    logic [19:0] shadow_digits, pend_digits;
    logic [4:0]  shadow_dp, pend_dp;
    logic        pend_valid;
    logic        wrap, boundary;
    logic [3:0]  cur_digit;
    logic [6:0]  segs;
    logic [4:0]  sel_next;
    logic [7:0]  data_next;
    logic        fs_next;
`ifdef LEADING_ZERO_BLANK_EN
    logic [2:0]  msd;
`endif

    function automatic logic [6:0] decode(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'h3F;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h6F;
            4'hA: s = 7'h77;
            4'hB: s = 7'h7C;
            4'hC: s = 7'h39;
            4'hD: s = 7'h5E;
            4'hE: s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

    always_comb begin
        wrap      = (cnt == CNT_LAST);
        boundary  = wrap && (idx == 3'd4);
        cnt_next  = wrap ? '0 : cnt + 1'b1;
        idx_next  = idx;
        if (wrap)
            idx_next = (idx == 3'd4) ? 3'd0 : idx + 3'd1;
        // state tracks which region the counter occupies
        state_next = (cnt_next < CNT_BLANK) ? BLANK : SHOW;

        cur_digit = shadow_digits[{idx, 2'b00} +: 4];
        segs      = decode(cur_digit);
`ifdef LEADING_ZERO_BLANK_EN
        // highest nonzero digit; digit 0 is always lit
        msd = 3'd0;
        for (int k = 1; k < 5; k++)
            if (shadow_digits[4*k +: 4] != 4'h0)
                msd = 3'(k);
        if (idx > msd)
            segs = 7'h00;
`endif

        sel_next  = 5'b0;
        data_next = 8'h00;
        if (state == SHOW) begin
            sel_next  = 5'b00001 << idx;
            data_next = {shadow_dp[idx], segs};
        end
        fs_next = (cnt == '0) && (idx == 3'd0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= BLANK;
            cnt           <= '0;
            idx           <= 3'd0;
            shadow_digits <= '0;
            shadow_dp     <= '0;
            pend_digits   <= '0;
            pend_dp       <= '0;
            pend_valid    <= 1'b0;
            seg_sel       <= '0;
            seg_data      <= '0;
            frame_start   <= 1'b0;
        end else begin
            state       <= state_next;
            cnt         <= cnt_next;
            idx         <= idx_next;
            seg_sel     <= sel_next;
            seg_data    <= data_next;
            frame_start <= fs_next;
            // a load coinciding with the boundary bypasses pending
            if (boundary && load) begin
                shadow_digits <= digits_in;
                shadow_dp     <= dp_in;
                pend_valid    <= 1'b0;
            end else if (boundary) begin
                if (pend_valid) begin
                    shadow_digits <= pend_digits;
                    shadow_dp     <= pend_dp;
                end
                pend_valid <= 1'b0;
            end else if (load) begin
                pend_digits <= digits_in;
                pend_dp     <= dp_in;
                pend_valid  <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_seven_seg_scanner.sv
// tb_seven_seg_scanner: randomized self-checking bench for seven_seg_scanner
// using a timeline model (DIGIT_CYCLES=8, BLANK_CYCLES=2).
module tb_seven_seg_scanner;

    localparam int DC = 8;
    localparam int BC = 2;
    localparam int FP = 5 * DC;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        load = 1'b0;
    logic [19:0] digits_in = '0;
    logic [4:0]  dp_in = '0;
    logic [4:0]  seg_sel;
    logic [7:0]  seg_data;
    logic        frame_start;

    seven_seg_scanner #(.DIGIT_CYCLES(DC), .BLANK_CYCLES(BC)) dut (
        .clk(clk), .reset(reset), .load(load),
        .digits_in(digits_in), .dp_in(dp_in),
        .seg_sel(seg_sel), .seg_data(seg_data),
        .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // model state: edges since reset release, displayed and pending values
    int          m = 0;
    logic [19:0] sh_d = '0, pend_d = '0;
    logic [4:0]  sh_p = '0, pend_p = '0;
    bit          pv = 1'b0;
    logic [4:0]  exp_sel;
    logic [7:0]  exp_data;
    logic        exp_fs;

    logic [6:0] dec_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D,
                                 7'h7D, 7'h07, 7'h7F, 7'h6F, 7'h77, 7'h7C,
                                 7'h39, 7'h5E, 7'h79, 7'h71};

    function automatic logic [6:0] seg_of(int i);
        logic [3:0] dg;
        dg = 4'((sh_d >> (4 * i)) & 20'hF);
`ifdef LEADING_ZERO_BLANK_EN
        if (i > 0 && (sh_d >> (4 * i)) == 20'h0)
            return 7'h00;
`endif
        return dec_tab[dg];
    endfunction

    // one clock: drive inputs, advance timeline model, leave expectations
    task automatic tick(input logic ld, input logic [19:0] d, input logic [4:0] p);
        int c, i;
        load = ld; digits_in = d; dp_in = p;
        @(posedge clk);
        if (reset) begin
            m = 0; sh_d = '0; sh_p = '0; pv = 1'b0;
            exp_sel = '0; exp_data = '0; exp_fs = 1'b0;
        end else begin
            m++;
            c = (m - 1) % DC;
            i = ((m - 1) / DC) % 5;
            exp_fs = ((m - 1) % FP == 0);
            if (c < BC) begin
                exp_sel = '0; exp_data = '0;
            end else begin
                exp_sel  = 5'(1 << i);
                exp_data = {sh_p[i], seg_of(i)};
            end
            if (m % FP == 0) begin
                if (ld) begin sh_d = d; sh_p = p; end
                else if (pv) begin sh_d = pend_d; sh_p = pend_p; end
                pv = 1'b0;
            end else if (ld) begin
                pend_d = d; pend_p = p; pv = 1'b1;
            end
        end
        #1;
        load = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick(1'b0, '0, '0);
            n_tests++;
            if (seg_sel !== 5'b0 || seg_data !== 8'h00 || frame_start !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_hold: sel=%b data=%h fs=%b want 0", seg_sel, seg_data, frame_start);
            end
        end
        reset = 1'b0;
        for (int k = 1; k <= 2 * FP + 2; k++) begin
            tick(1'b0, '0, '0);
            n_tests++;
            if (seg_sel !== exp_sel || seg_data !== exp_data || frame_start !== exp_fs) begin
                n_fail++;
                $display("FAIL reset_scan k=%0d: sel=%b data=%h fs=%b want sel=%b data=%h fs=%b",
                         k, seg_sel, seg_data, frame_start, exp_sel, exp_data, exp_fs);
            end
            if (k == 3) begin
                n_tests++;
                if (seg_sel !== 5'b00001 || seg_data !== 8'h3F) begin
                    n_fail++;
                    $display("FAIL first_digit: sel=%b data=%h want 00001/3f", seg_sel, seg_data);
                end
            end
        end
    endtask

    task automatic test_load_mid_frame();
        bit seen = 1'b0;
        for (int k = 0; k < 7; k++) tick(1'b0, '0, '0);
        tick(1'b1, 20'h12345, 5'b00100);
        for (int k = 0; k < 2 * FP; k++) begin
            tick(1'b0, '0, '0);
            n_tests++;
            if (seg_sel !== exp_sel || seg_data !== exp_data || frame_start !== exp_fs) begin
                n_fail++;
                $display("FAIL load_mid: sel=%b data=%h fs=%b want sel=%b data=%h fs=%b",
                         seg_sel, seg_data, frame_start, exp_sel, exp_data, exp_fs);
            end
            if (!seen && sh_d == 20'h12345 && exp_sel == 5'b00100) begin
                seen = 1'b1;
                n_tests++;
                if (seg_data !== 8'hCF) begin
                    n_fail++;
                    $display("FAIL digit2_dp: data=%h want cf", seg_data);
                end
            end
        end
    endtask

    task automatic test_double_load();
        tick(1'b1, 20'h11111, 5'b0);
        tick(1'b0, '0, '0);
        tick(1'b1, 20'h98765, 5'b00001);
        for (int k = 0; k < 2 * FP + 5; k++) begin
            tick(1'b0, '0, '0);
            n_tests++;
            if (seg_sel !== exp_sel || seg_data !== exp_data || frame_start !== exp_fs) begin
                n_fail++;
                $display("FAIL double_load: sel=%b data=%h want sel=%b data=%h",
                         seg_sel, seg_data, exp_sel, exp_data);
            end
        end
    endtask

    task automatic test_boundary_load();
        for (int k = 0; k < FP && (m % FP) != FP - 1; k++) tick(1'b0, '0, '0);
        tick(1'b1, 20'h0000F, 5'b0);
        for (int k = 1; k <= FP + 4; k++) begin
            tick(1'b0, '0, '0);
            n_tests++;
            if (seg_sel !== exp_sel || seg_data !== exp_data || frame_start !== exp_fs) begin
                n_fail++;
                $display("FAIL boundary_load: sel=%b data=%h want sel=%b data=%h",
                         seg_sel, seg_data, exp_sel, exp_data);
            end
            if (k == 3) begin
                n_tests++;
                if (seg_sel !== 5'b00001 || seg_data !== 8'h71) begin
                    n_fail++;
                    $display("FAIL boundary_digit0: sel=%b data=%h want 00001/71", seg_sel, seg_data);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        bit timeout = 1'b1;
        tick(1'b1, 20'h44444, 5'b11111);
        for (int k = 0; k < 3 * FP; k++) begin
            tick(1'b0, '0, '0);
            if (seg_sel == 5'b01000) begin timeout = 1'b0; break; end
        end
        n_tests++;
        if (timeout) begin
            n_fail++;
            $display("FAIL reset_mid_wait: digit3 never lit");
        end
        reset = 1'b1;
        tick(1'b0, '0, '0);
        reset = 1'b0;
        n_tests++;
        if (seg_sel !== 5'b0 || seg_data !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_mid: sel=%b data=%h want 0", seg_sel, seg_data);
        end
        for (int k = 0; k < FP + 5; k++) begin
            tick(1'b0, '0, '0);
            n_tests++;
            if (seg_sel !== exp_sel || seg_data !== exp_data || frame_start !== exp_fs) begin
                n_fail++;
                $display("FAIL reset_restart: sel=%b data=%h fs=%b want sel=%b data=%h fs=%b",
                         seg_sel, seg_data, frame_start, exp_sel, exp_data, exp_fs);
            end
        end
    endtask

`ifdef LEADING_ZERO_BLANK_EN
    task automatic test_leading_zero();
        logic [19:0] vals [2] = '{20'h00070, 20'h00000};
        for (int v = 0; v < 2; v++) begin
            tick(1'b1, vals[v], 5'b0);
            for (int k = 0; k < 2 * FP; k++) begin
                tick(1'b0, '0, '0);
                n_tests++;
                if (seg_sel !== exp_sel || seg_data !== exp_data) begin
                    n_fail++;
                    $display("FAIL lzb: sel=%b data=%h want sel=%b data=%h",
                             seg_sel, seg_data, exp_sel, exp_data);
                end
            end
        end
    endtask
`endif

    task automatic test_random();
        for (int k = 0; k < 600; k++) begin
            tick($urandom_range(0, 24) == 0, 20'($urandom), 5'($urandom));
            n_tests++;
            if (seg_sel !== exp_sel || seg_data !== exp_data || frame_start !== exp_fs) begin
                n_fail++;
                $display("FAIL random k=%0d: sel=%b data=%h fs=%b want sel=%b data=%h fs=%b",
                         k, seg_sel, seg_data, frame_start, exp_sel, exp_data, exp_fs);
            end
        end
    endtask

    initial begin
        test_reset();
        test_load_mid_frame();
        test_double_load();
        test_boundary_load();
        test_reset_mid();
`ifdef LEADING_ZERO_BLANK_EN
        test_leading_zero();
`endif
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
